// File: rtl/c_err_log_pkg.sv
// Shared types and helpers for the error capture/logging block.
package c_err_log_pkg;

    // How the registered error flags behave once an error has been seen.
    typedef enum logic [1:0] {
        CAPTURE_NONE       = 2'd0,
        CAPTURE_NO_HOLD    = 2'd1,
        CAPTURE_HOLD_FIRST = 2'd2,
        CAPTURE_HOLD_ALL   = 2'd3
    } capture_mode_e;

    // Ceiling log2; clogb(1) = 0.
    function automatic int unsigned clogb(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width of the first-error index; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (clogb(n) < 1) ? 1 : clogb(n);
    endfunction

endpackage

// File: rtl/c_err_log_if.sv
// Error-log bus: control/error inputs from the source side, logged state back.
//   master: drives active, clear, err_mask, errors_in; observes logged state
//   slave : the logging block
interface c_err_log_if
    import c_err_log_pkg::*;
#(
    parameter int unsigned num_errors  = 1,
    parameter int unsigned count_width = 8
);
    localparam int unsigned IDX_W = idx_w(num_errors);

    logic                              active;
    logic                              clear;
    logic [num_errors-1:0]             err_mask;
    logic [num_errors-1:0]             errors_in;
    logic [num_errors-1:0]             errors_out;
    logic [num_errors*count_width-1:0] err_counts;
    logic [num_errors-1:0]             cnt_sat;
    logic                              first_valid;
    logic [IDX_W-1:0]                  first_idx;
    logic                              irq;

    modport master (
        output active, clear, err_mask, errors_in,
        input  errors_out, err_counts, cnt_sat, first_valid, first_idx, irq
    );

    modport slave (
        input  active, clear, err_mask, errors_in,
        output errors_out, err_counts, cnt_sat, first_valid, first_idx, irq
    );
endinterface

// File: rtl/c_err_log_sat_ctr.sv
// Saturating event counter with enable, clear-load and registered saturation flag.
//   clk, reset : clock, synchronous active-high reset
//   en         : update enable (0 = hold)
//   load       : load count with inc instead of incrementing
//   inc        : event strobe
//   count, sat : counter value, counter at all-ones
module c_err_log_sat_ctr #(
    parameter int unsigned width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic             inc,
    output logic [width-1:0] count,
    output logic             sat
);
    localparam logic [width-1:0] CNT_MAX = '1;

    logic [width-1:0] cnt_q;
    logic [width-1:0] cnt_n;
    logic             sat_q;

    // Next count: load takes the coincident event so it is never lost.
    always_comb begin
        cnt_n = cnt_q;
        if (load) begin
            cnt_n = width'(inc);
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_n = cnt_q + width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else if (en) begin
            cnt_q <= cnt_n;
            sat_q <= (cnt_n == CNT_MAX);
        end
    end

    assign count = cnt_q;
    assign sat   = sat_q;
endmodule

// File: rtl/c_err_log.sv
// Error capture/logging: masked error flags with selectable hold mode,
// per-error saturating counters, first-error index latch and summary irq.
//   clk, reset : clock, synchronous active-high reset
//   bus        : c_err_log_if slave (active, clear, err_mask, errors_in in;
//                errors_out, err_counts, cnt_sat, first_valid, first_idx, irq out)
module c_err_log
    import c_err_log_pkg::*;
#(
    parameter int unsigned   num_errors   = 1,
    parameter capture_mode_e capture_mode = CAPTURE_NO_HOLD,
    parameter int unsigned   count_width  = 8
) (
    input  logic        clk,
    input  logic        reset,
    c_err_log_if.slave  bus
);
    localparam int unsigned IDX_W   = idx_w(num_errors);
    localparam bit          IS_NONE = (capture_mode == CAPTURE_NONE);

    logic [num_errors-1:0]  e;
    logic [num_errors-1:0]  err_q;
    logic [num_errors-1:0]  err_base;
    logic [num_errors-1:0]  err_n;
    logic                   fv_q;
    logic                   fv_n;
    logic [IDX_W-1:0]       idx_q;
    logic [IDX_W-1:0]       idx_n;
    logic [IDX_W-1:0]       idx_lo;
    logic                   irq_q;
    logic [count_width-1:0] cnt_arr [num_errors];
    logic [num_errors-1:0]  sat_vec;
    logic [num_errors*count_width-1:0] cnt_flat;

    // Masked events; NONE mode never sees any, so all state stays at reset.
    assign e = IS_NONE ? '0 : (bus.errors_in & bus.err_mask);

    // Lowest set index of e.
    always_comb begin
        idx_lo = '0;
        for (int i = int'(num_errors) - 1; i >= 0; i--) begin
            if (e[i]) idx_lo = IDX_W'(i);
        end
    end

    // Clear evaluates every mode from an empty state, so coincident errors survive.
    always_comb begin
        err_base = bus.clear ? '0 : err_q;
        case (capture_mode)
            CAPTURE_NO_HOLD:    err_n = e;
            CAPTURE_HOLD_FIRST: err_n = (err_base == '0) ? e : err_base;
            CAPTURE_HOLD_ALL:   err_n = err_base | e;
            default:            err_n = '0;
        endcase

        fv_n  = bus.clear ? 1'b0 : fv_q;
        idx_n = bus.clear ? '0   : idx_q;
        if (!fv_n && (e != '0)) begin
            fv_n  = 1'b1;
            idx_n = idx_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= '0;
            fv_q  <= 1'b0;
            idx_q <= '0;
            irq_q <= 1'b0;
        end else if (bus.active) begin
            err_q <= err_n;
            fv_q  <= fv_n;
            idx_q <= idx_n;
            irq_q <= |err_n;
        end
    end

    for (genvar g = 0; g < int'(num_errors); g++) begin : g_ctr
        c_err_log_sat_ctr #(.width(count_width)) u_ctr (
            .clk   (clk),
            .reset (reset),
            .en    (bus.active),
            .load  (bus.clear),
            .inc   (e[g]),
            .count (cnt_arr[g]),
            .sat   (sat_vec[g])
        );
    end

    always_comb begin
        cnt_flat = '0;
        for (int i = 0; i < int'(num_errors); i++) begin
            cnt_flat[i*count_width +: count_width] = cnt_arr[i];
        end
    end

    assign bus.errors_out  = IS_NONE ? '0   : err_q;
    assign bus.err_counts  = IS_NONE ? '0   : cnt_flat;
    assign bus.cnt_sat     = IS_NONE ? '0   : sat_vec;
    assign bus.first_valid = IS_NONE ? 1'b0 : fv_q;
    assign bus.first_idx   = IS_NONE ? '0   : idx_q;
    assign bus.irq         = IS_NONE ? 1'b0 : irq_q;
endmodule

// File: tb/tb_c_err_log.sv
// Directed bench: four instances (HOLD_FIRST/cw8, HOLD_ALL/cw3, NO_HOLD/cw8, NONE)
// share one stimulus stream; expected values are hand-computed constants.
module tb_c_err_log;
    import c_err_log_pkg::*;

    logic       clk;
    logic       reset;
    logic       active;
    logic       clear;
    logic [3:0] err_mask;
    logic [3:0] errors_in;

    int checks   = 0;
    int failures = 0;

    c_err_log_if #(.num_errors(4), .count_width(8)) bus_hf ();
    c_err_log_if #(.num_errors(4), .count_width(3)) bus_ha ();
    c_err_log_if #(.num_errors(4), .count_width(8)) bus_nh ();
    c_err_log_if #(.num_errors(4), .count_width(8)) bus_nn ();

    assign bus_hf.active = active;  assign bus_hf.clear = clear;
    assign bus_hf.err_mask = err_mask;  assign bus_hf.errors_in = errors_in;
    assign bus_ha.active = active;  assign bus_ha.clear = clear;
    assign bus_ha.err_mask = err_mask;  assign bus_ha.errors_in = errors_in;
    assign bus_nh.active = active;  assign bus_nh.clear = clear;
    assign bus_nh.err_mask = err_mask;  assign bus_nh.errors_in = errors_in;
    assign bus_nn.active = active;  assign bus_nn.clear = clear;
    assign bus_nn.err_mask = err_mask;  assign bus_nn.errors_in = errors_in;

    c_err_log #(.num_errors(4), .capture_mode(CAPTURE_HOLD_FIRST), .count_width(8))
        dut_hf (.clk(clk), .reset(reset), .bus(bus_hf));
    c_err_log #(.num_errors(4), .capture_mode(CAPTURE_HOLD_ALL), .count_width(3))
        dut_ha (.clk(clk), .reset(reset), .bus(bus_ha));
    c_err_log #(.num_errors(4), .capture_mode(CAPTURE_NO_HOLD), .count_width(8))
        dut_nh (.clk(clk), .reset(reset), .bus(bus_nh));
    c_err_log #(.num_errors(4), .capture_mode(CAPTURE_NONE), .count_width(8))
        dut_nn (.clk(clk), .reset(reset), .bus(bus_nn));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; clear = 1'b0; errors_in = 4'b0000;
        step();
        reset = 1'b0;
    endtask

    task automatic check_hf(input string tag, input logic [3:0] eo, input logic [31:0] cnt,
                            input logic fv, input logic [1:0] idx, input logic irq);
        check({tag, ".hf.errors_out"},  32'(bus_hf.errors_out),  32'(eo));
        check({tag, ".hf.err_counts"},  bus_hf.err_counts,       cnt);
        check({tag, ".hf.first_valid"}, 32'(bus_hf.first_valid), 32'(fv));
        check({tag, ".hf.first_idx"},   32'(bus_hf.first_idx),   32'(idx));
        check({tag, ".hf.irq"},         32'(bus_hf.irq),         32'(irq));
    endtask

    initial begin
        reset = 1'b1; active = 1'b0; clear = 1'b0;
        err_mask = 4'b1111; errors_in = 4'b0000;
        step();
        check_hf("reset", 4'b0000, 32'h0, 1'b0, 2'd0, 1'b0);
        check("reset.ha.errors_out", 32'(bus_ha.errors_out), 32'h0);
        check("reset.ha.err_counts", 32'(bus_ha.err_counts), 32'h0);

        // HOLD_FIRST capture
        reset = 1'b0; active = 1'b1;
        errors_in = 4'b0100; step();
        check_hf("hf1", 4'b0100, 32'h0001_0000, 1'b1, 2'd2, 1'b1);
        errors_in = 4'b0011; step();
        check_hf("hf2", 4'b0100, 32'h0001_0101, 1'b1, 2'd2, 1'b1);

        // HOLD_ALL vs NO_HOLD
        do_reset();
        errors_in = 4'b1000; step();
        check("ha1", 32'(bus_ha.errors_out), 32'b1000);
        check("nh1", 32'(bus_nh.errors_out), 32'b1000);
        errors_in = 4'b0001; step();
        check("ha2", 32'(bus_ha.errors_out), 32'b1001);
        check("nh2", 32'(bus_nh.errors_out), 32'b0001);
        errors_in = 4'b0000; step();
        check("ha3", 32'(bus_ha.errors_out), 32'b1001);
        check("nh3", 32'(bus_nh.errors_out), 32'b0000);
        check("ha3.irq", 32'(bus_ha.irq), 32'h1);
        check("nh3.irq", 32'(bus_nh.irq), 32'h0);
        check("nh3.first_idx", 32'(bus_nh.first_idx), 32'd3);

        // 3-bit counter saturation on error 0
        do_reset();
        errors_in = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("sat.cnt%0d", k), 32'(bus_ha.err_counts[2:0]), (k < 7) ? 32'(k) : 32'd7);
            check($sformatf("sat.flag%0d", k), 32'(bus_ha.cnt_sat[0]), (k >= 7) ? 32'd1 : 32'd0);
        end

        // Clear with a coincident error
        do_reset();
        errors_in = 4'b0101; step();
        step();
        check_hf("preclr", 4'b0101, 32'h0002_0002, 1'b1, 2'd0, 1'b1);
        clear = 1'b1; errors_in = 4'b0010; step();
        clear = 1'b0;
        check_hf("clr", 4'b0010, 32'h0000_0100, 1'b1, 2'd1, 1'b1);
        check("clr.ha.err_counts", 32'(bus_ha.err_counts), 32'h008);

        // Inactive: nothing moves, clear ignored
        active = 1'b0; errors_in = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            clear = (k == 2);
            step();
            check_hf($sformatf("inact%0d", k), 4'b0010, 32'h0000_0100, 1'b1, 2'd1, 1'b1);
        end
        clear = 1'b0;

        // Burst, then reset together with clear
        active = 1'b1; errors_in = 4'b1111; step();
        check_hf("burst", 4'b0010, 32'h0101_0201, 1'b1, 2'd1, 1'b1);
        check("none.errors_out", 32'(bus_nn.errors_out), 32'h0);
        check("none.err_counts", bus_nn.err_counts, 32'h0);
        check("none.irq", 32'(bus_nn.irq), 32'h0);
        check("none.first_valid", 32'(bus_nn.first_valid), 32'h0);
        reset = 1'b1; clear = 1'b1; step();
        reset = 1'b0; clear = 1'b0;
        check_hf("rstclr", 4'b0000, 32'h0, 1'b0, 2'd0, 1'b0);

        // Masking
        err_mask = 4'b1110; errors_in = 4'b0001; step();
        check_hf("mask0", 4'b0000, 32'h0, 1'b0, 2'd0, 1'b0);
        errors_in = 4'b0010; step();
        check_hf("mask1", 4'b0010, 32'h0000_0100, 1'b1, 2'd1, 1'b1);
        err_mask = 4'b1100; step();
        check_hf("mask2", 4'b0010, 32'h0000_0100, 1'b1, 2'd1, 1'b1);
        check("mask2.nh", 32'(bus_nh.errors_out), 32'h0);
        check("mask2.nh.cnt", bus_nh.err_counts, 32'h0000_0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
